axi_wr_slave: RTL and testbench
===============================

# axi_wr_slave

AXI-style write-channel slave at the front of the DDR2 controller, directly downstream of the AXI write master. Accepts one AW burst at a time, buffers its W beats locally, hands the burst to the controller core as a single write request, then returns a B response. Only one outstanding burst exists; AW/W/B handshakes are serialised.

## Interface
- ADDR_WIDTH, default `ROW_BITS+`COL_BITS+`BA_BITS, byte/word address width on AW and core side
- DATA_WIDTH, default `DQ_BITS*2, beat width (one DDR2 clock worth of data)
- BUF_DEPTH, default 16, beats held in write buffer; must be a power of two
- clk  in  1  controller clock
- rstn  in  1  reset, asynchronous, active-low
- init_end  in  1  DDR2 init complete; no AW accepted while low
- awvalid  in  1 / awready  out  1 / awaddr  in  ADDR_WIDTH / awlen  in  8  (beats = awlen+1)
- wvalid  in  1 / wready  out  1 / wdata  in  DATA_WIDTH / wlast  in  1
- bvalid  out  1 / bready  in  1 / bresp  out  2  (2'b00 OKAY, 2'b10 SLVERR)
- wr_req  out  1  burst ready for core; held until wr_ack
- wr_ack  in  1  core accepted request (single-cycle pulse)
- wr_addr  out  ADDR_WIDTH / wr_len  out  8  captured awaddr/awlen, stable from wr_req to wr_done
- wr_data_en  in  1  core pops one beat this cycle
- wr_data  out  DATA_WIDTH  buffer head beat
- wr_done  in  1  core finished burst on DRAM (single-cycle pulse)

## Operation
- States: IDLE, WDATA, REQ, XFER, RESP. Reset -> IDLE; all outputs 0, pointers/counters 0, bresp 2'b00.
- IDLE: awready = init_end. awvalid&awready -> capture awaddr/awlen, clear beat count and error flag, -> WDATA. Error flag set if awlen > BUF_DEPTH-1.
- WDATA: wready=1. Each wvalid&wready: write wdata to buffer (unless error flag), count++. wlast on beat other than beat awlen+1 sets error flag. Beat awlen+1 accepted -> if error flag: RESP with SLVERR (no core request, buffer discarded); else REQ. wlast missing on final beat also sets error -> SLVERR.
- REQ: wr_req=1, wr_addr/wr_len driven. wr_ack -> XFER.
- XFER: wr_data = buf[rd_ptr] (combinational read of registered array); wr_data_en advances rd_ptr. Extra wr_data_en beyond awlen+1 pops ignored, rd_ptr saturates. wr_done -> RESP with OKAY.
- RESP: bvalid=1, bresp stable until bvalid&bready, then -> IDLE, pointers cleared.
- rstn asserted in any state: immediate return to IDLE, burst lost, no B issued.
- Beat counter 8-bit; buffer pointers log2(BUF_DEPTH) bits, never wrap within one legal burst.

## Timing
- awready combinational from state and init_end; AW handshake at T -> wready high at T+1.
- Final W beat at T -> wr_req (or bvalid for error) at T+1.
- wr_ack at T -> wr_req low at T+1; wr_data valid from T+1.
- wr_data_en at T -> next beat on wr_data at T+1.
- wr_done at T -> bvalid at T+1; B handshake at T -> awready may be high at T+1.
- Min burst turnaround: 1 (AW) + beats + 1 (REQ, if same-cycle ack) + core time + 1 (B).
- wr_ack/wr_done/wr_data_en outside REQ/XFER ignored.

## Structure
- Shared define/package: ADDR_WIDTH/DATA_WIDTH derivations, BRESP_OKAY/BRESP_SLVERR, state encodings.
- One sub-module: axi_wbuf (BUF_DEPTH x DATA_WIDTH register array, sync write, async read port).
- FSM, counters and flag in axi_wr_slave.

## Test plan
- init_end=0, awvalid=1 -> awready stays 0; init_end=1 -> AW accepted next cycle.
- awaddr=16, awlen=8, 9 beats 0..8 with wlast on 9th -> wr_req, wr_addr=16, wr_len=8; core pops 9 beats reading 0..8 in order; wr_done -> bvalid, bresp=00.
- awlen=20 (> BUF_DEPTH-1) -> all 21 beats accepted, no wr_req, bresp=2'b10.
- wlast on beat 3 of awlen=8 -> remaining beats still accepted, bresp=2'b10, no wr_req.
- bready held low 5 cycles in RESP -> bvalid/bresp stable, awready low until handshake.
- rstn pulsed mid-XFER -> all outputs 0 next edge, IDLE; fresh burst then completes OKAY.

Source files
------------

// File: rtl/axi_wr_slave_pkg.sv
// Shared widths, response codes and FSM encoding for the AXI write-channel slave.
// Widths derive from the DDR2 geometry used across the controller.
package axi_wr_slave_pkg;

    localparam int ROW_BITS   = 13;
    localparam int COL_BITS   = 10;
    localparam int BA_BITS    = 2;
    localparam int DQ_BITS    = 16;

    localparam int ADDR_W_DEF = ROW_BITS + COL_BITS + BA_BITS;
    localparam int DATA_W_DEF = DQ_BITS * 2;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WDATA = 3'd1,
        ST_REQ   = 3'd2,
        ST_XFER  = 3'd3,
        ST_RESP  = 3'd4
    } wr_state_e;

    // A burst longer than the buffer cannot be held and is answered with SLVERR.
    function automatic logic burst_too_long(input logic [7:0] len, input logic [7:0] max_len);
        return (len > max_len);
    endfunction

endpackage

// File: rtl/axi_wr_slave_if.sv
// AW/W/B channel bundle between the AXI write master and the write slave.
interface axi_wr_slave_if #(
    parameter int ADDR_WIDTH = axi_wr_slave_pkg::ADDR_W_DEF,
    parameter int DATA_WIDTH = axi_wr_slave_pkg::DATA_W_DEF
) ();

    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;

    logic                  wvalid;
    logic                  wready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wlast;

    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;

    modport master (
        output awvalid, awaddr, awlen, wvalid, wdata, wlast, bready,
        input  awready, wready, bvalid, bresp
    );

    modport slave (
        input  awvalid, awaddr, awlen, wvalid, wdata, wlast, bready,
        output awready, wready, bvalid, bresp
    );

endinterface

// File: rtl/axi_wr_slave_wbuf.sv
// Write beat buffer: register array with a synchronous write port and an
// asynchronous read port so the core sees the head beat without latency.
module axi_wbuf #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Beat storage; contents are don't-care until written in the current burst.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/axi_wr_slave.sv
// AXI write-channel slave: accepts one AW burst, buffers its W beats, hands the
// burst to the DDR2 core as a single request and then returns the B response.
module axi_wr_slave
    import axi_wr_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W_DEF,
    parameter int DATA_WIDTH = DATA_W_DEF,
    parameter int BUF_DEPTH  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  init_end,
    axi_wr_slave_if.slave         axi,
    output logic                  wr_req,
    input  logic                  wr_ack,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [7:0]            wr_len,
    input  logic                  wr_data_en,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_done
);

    localparam int         PTR_W   = $clog2(BUF_DEPTH);
    localparam logic [7:0] MAX_LEN = 8'(BUF_DEPTH - 1);

    wr_state_e             state_r;
    wr_state_e             state_s;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [7:0]            len_r;
    logic [7:0]            beat_cnt_r;
    logic                  err_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [1:0]            bresp_r;

    logic                  awready_s;
    logic                  wready_s;
    logic                  bvalid_s;
    logic                  wr_req_s;
    logic                  aw_hs_s;
    logic                  w_hs_s;
    logic                  b_hs_s;
    logic                  last_beat_s;
    logic                  burst_err_s;
    logic                  buf_we_s;
    logic                  rd_more_s;
    logic [DATA_WIDTH-1:0] buf_rdata_s;

    // Handshakes decoded straight from the state register to keep awready free of loops.
    assign aw_hs_s     = axi.awvalid & init_end & (state_r == ST_IDLE);
    assign w_hs_s      = axi.wvalid & (state_r == ST_WDATA);
    assign b_hs_s      = axi.bready & (state_r == ST_RESP);
    assign last_beat_s = (beat_cnt_r == len_r);
    // A wlast that disagrees with the beat count in either direction poisons the burst.
    assign burst_err_s = err_r | (axi.wlast ^ last_beat_s);
    assign buf_we_s    = w_hs_s & ~err_r;
    assign rd_more_s   = (8'(rd_ptr_r) < len_r);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and channel-control decode.
    always_comb begin
        state_s   = state_r;
        awready_s = 1'b0;
        wready_s  = 1'b0;
        bvalid_s  = 1'b0;
        wr_req_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                awready_s = init_end;
                if (aw_hs_s) begin
                    state_s = ST_WDATA;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WDATA: begin
                wready_s = 1'b1;
                if (w_hs_s && last_beat_s) begin
                    state_s = burst_err_s ? ST_RESP : ST_REQ;
                end else begin
                    state_s = ST_WDATA;
                end
            end
            ST_REQ: begin
                wr_req_s = 1'b1;
                if (wr_ack) begin
                    state_s = ST_XFER;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_XFER: begin
                if (wr_done) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_XFER;
                end
            end
            ST_RESP: begin
                bvalid_s = 1'b1;
                if (b_hs_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Burst descriptor, beat counter, error flag, read pointer and response code.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_r     <= '0;
            len_r      <= 8'd0;
            beat_cnt_r <= 8'd0;
            err_r      <= 1'b0;
            rd_ptr_r   <= '0;
            bresp_r    <= BRESP_OKAY;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (aw_hs_s) begin
                        addr_r     <= axi.awaddr;
                        len_r      <= axi.awlen;
                        beat_cnt_r <= 8'd0;
                        err_r      <= burst_too_long(axi.awlen, MAX_LEN);
                        rd_ptr_r   <= '0;
                        bresp_r    <= BRESP_OKAY;
                    end
                end
                ST_WDATA: begin
                    if (w_hs_s) begin
                        err_r <= burst_err_s;
                        if (last_beat_s) begin
                            bresp_r <= burst_err_s ? BRESP_SLVERR : BRESP_OKAY;
                        end else begin
                            beat_cnt_r <= beat_cnt_r + 8'd1;
                        end
                    end
                end
                ST_XFER: begin
                    // Pops past the final beat leave the pointer parked on it.
                    if (wr_data_en && rd_more_s) begin
                        rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
                    end
                    if (wr_done) begin
                        bresp_r <= BRESP_OKAY;
                    end
                end
                ST_RESP: begin
                    if (b_hs_s) begin
                        beat_cnt_r <= 8'd0;
                        rd_ptr_r   <= '0;
                        err_r      <= 1'b0;
                        bresp_r    <= BRESP_OKAY;
                    end
                end
                default: begin
                    beat_cnt_r <= 8'd0;
                end
            endcase
        end
    end

    axi_wbuf #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (DATA_WIDTH),
        .PTR_W (PTR_W)
    ) u_wbuf (
        .clk   (clk),
        .we    (buf_we_s),
        .waddr (beat_cnt_r[PTR_W-1:0]),
        .wdata (axi.wdata),
        .raddr (rd_ptr_r),
        .rdata (buf_rdata_s)
    );

    assign axi.awready = awready_s;
    assign axi.wready  = wready_s;
    assign axi.bvalid  = bvalid_s;
    assign axi.bresp   = bresp_r;
    assign wr_req      = wr_req_s;
    assign wr_addr     = addr_r;
    assign wr_len      = len_r;
    // Buffer contents are only presented while the core is draining them.
    assign wr_data     = (state_r == ST_XFER) ? buf_rdata_s : '0;

endmodule

// File: tb/tb_axi_wr_slave.sv
// Directed self-checking bench for axi_wr_slave.
module tb_axi_wr_slave;
    import axi_wr_slave_pkg::*;

    localparam int AW = ADDR_W_DEF;
    localparam int DW = DATA_W_DEF;

    logic          clk;
    logic          rstn;
    logic          init_end;
    logic          wr_req;
    logic          wr_ack;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_len;
    logic          wr_data_en;
    logic [DW-1:0] wr_data;
    logic          wr_done;

    int checks;
    int errors;

    axi_wr_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    axi_wr_slave #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BUF_DEPTH  (16)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .init_end   (init_end),
        .axi        (axi),
        .wr_req     (wr_req),
        .wr_ack     (wr_ack),
        .wr_addr    (wr_addr),
        .wr_len     (wr_len),
        .wr_data_en (wr_data_en),
        .wr_data    (wr_data),
        .wr_done    (wr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_beats(input int n, input int last_at, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            axi.wvalid = 1'b1;
            axi.wdata  = base + DW'(i);
            axi.wlast  = (i == last_at);
            tick();
        end
        axi.wvalid = 1'b0;
        axi.wlast  = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstn = 1'b0; init_end = 1'b0;
        wr_ack = 1'b0; wr_data_en = 1'b0; wr_done = 1'b0;
        axi.awvalid = 1'b0; axi.awaddr = '0; axi.awlen = 8'd0;
        axi.wvalid = 1'b0; axi.wdata = '0; axi.wlast = 1'b0;
        axi.bready = 1'b0;

        tick(); tick();
        chk("rst_awready", 64'(axi.awready), 64'd0);
        chk("rst_wready",  64'(axi.wready),  64'd0);
        chk("rst_bvalid",  64'(axi.bvalid),  64'd0);
        chk("rst_bresp",   64'(axi.bresp),   64'd0);
        chk("rst_wr_req",  64'(wr_req),      64'd0);
        chk("rst_wr_addr", 64'(wr_addr),     64'd0);
        chk("rst_wr_data", 64'(wr_data),     64'd0);
        rstn = 1'b1;

        // AW held off until DDR2 init completes
        axi.awvalid = 1'b1; axi.awaddr = AW'(16); axi.awlen = 8'd8;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("noinit_awready", 64'(axi.awready), 64'd0);
        end
        init_end = 1'b1;
        #1;
        chk("init_awready", 64'(axi.awready), 64'd1);
        tick();
        axi.awvalid = 1'b0;
        chk("aw_wready", 64'(axi.wready), 64'd1);
        chk("aw_awready_low", 64'(axi.awready), 64'd0);

        // Good burst: 9 beats 0..8
        send_beats(9, 8, DW'(0));
        chk("b1_wr_req",  64'(wr_req),     64'd1);
        chk("b1_wr_addr", 64'(wr_addr),    64'd16);
        chk("b1_wr_len",  64'(wr_len),     64'd8);
        chk("b1_wready",  64'(axi.wready), 64'd0);
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        chk("b1_req_drop", 64'(wr_req), 64'd0);
        for (int i = 0; i < 9; i++) begin
            chk("b1_pop_data", 64'(wr_data), 64'(i));
            wr_data_en = 1'b1;
            tick();
        end
        chk("b1_sat_data", 64'(wr_data), 64'd8);
        tick();
        wr_data_en = 1'b0;
        chk("b1_sat_extra", 64'(wr_data), 64'd8);
        chk("b1_no_bvalid", 64'(axi.bvalid), 64'd0);
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        chk("b1_bvalid", 64'(axi.bvalid), 64'd1);
        chk("b1_bresp",  64'(axi.bresp),  64'd0);
        axi.bready = 1'b1;
        tick();
        axi.bready = 1'b0;
        chk("b1_bvalid_drop", 64'(axi.bvalid),  64'd0);
        chk("b1_awready",     64'(axi.awready), 64'd1);

        // Oversized burst: awlen=20
        axi.awvalid = 1'b1; axi.awaddr = AW'(64); axi.awlen = 8'd20;
        tick();
        axi.awvalid = 1'b0;
        send_beats(20, 20, DW'(100));
        chk("big_wready_last", 64'(axi.wready), 64'd1);
        send_beats(1, 0, DW'(120));
        chk("big_wr_req", 64'(wr_req),     64'd0);
        chk("big_bvalid", 64'(axi.bvalid), 64'd1);
        chk("big_bresp",  64'(axi.bresp),  64'd2);
        axi.bready = 1'b1;
        tick();
        axi.bready = 1'b0;
        chk("big_bdone", 64'(axi.bvalid), 64'd0);

        // Early wlast on third beat of a 9-beat burst
        axi.awvalid = 1'b1; axi.awaddr = AW'(48); axi.awlen = 8'd8;
        tick();
        axi.awvalid = 1'b0;
        send_beats(3, 2, DW'(200));
        chk("early_wready", 64'(axi.wready), 64'd1);
        send_beats(6, 5, DW'(203));
        chk("early_wr_req", 64'(wr_req),     64'd0);
        chk("early_bvalid", 64'(axi.bvalid), 64'd1);
        chk("early_bresp",  64'(axi.bresp),  64'd2);

        // Back-pressure on B while a new AW waits
        axi.awvalid = 1'b1; axi.awaddr = AW'(128); axi.awlen = 8'd3;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_bvalid",  64'(axi.bvalid),  64'd1);
            chk("stall_bresp",   64'(axi.bresp),   64'd2);
            chk("stall_awready", 64'(axi.awready), 64'd0);
        end
        axi.bready = 1'b1;
        tick();
        axi.bready = 1'b0;
        chk("stall_release", 64'(axi.awready), 64'd1);
        tick();
        axi.awvalid = 1'b0;
        send_beats(4, 3, DW'(160));
        chk("r_wr_req",  64'(wr_req),  64'd1);
        chk("r_wr_addr", 64'(wr_addr), 64'd128);
        chk("r_wr_len",  64'(wr_len),  64'd3);
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        chk("r_data0", 64'(wr_data), 64'd160);
        wr_data_en = 1'b1;
        tick();
        wr_data_en = 1'b0;
        chk("r_data1", 64'(wr_data), 64'd161);

        // Reset in the middle of XFER
        rstn = 1'b0;
        #1;
        chk("mid_rst_wr_req",  64'(wr_req),      64'd0);
        chk("mid_rst_wready",  64'(axi.wready),  64'd0);
        chk("mid_rst_bvalid",  64'(axi.bvalid),  64'd0);
        chk("mid_rst_wr_addr", 64'(wr_addr),     64'd0);
        chk("mid_rst_wr_len",  64'(wr_len),      64'd0);
        chk("mid_rst_wr_data", 64'(wr_data),     64'd0);
        tick();
        rstn = 1'b1;
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        chk("post_rst_no_b", 64'(axi.bvalid), 64'd0);

        // Fresh burst after reset
        axi.awvalid = 1'b1; axi.awaddr = AW'(32); axi.awlen = 8'd1;
        tick();
        axi.awvalid = 1'b0;
        axi.wvalid = 1'b1; axi.wdata = DW'(85); axi.wlast = 1'b0;
        tick();
        axi.wdata = DW'(102); axi.wlast = 1'b1;
        tick();
        axi.wvalid = 1'b0; axi.wlast = 1'b0;
        chk("f_wr_req",  64'(wr_req),  64'd1);
        chk("f_wr_addr", 64'(wr_addr), 64'd32);
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        chk("f_data0", 64'(wr_data), 64'd85);
        wr_data_en = 1'b1;
        tick();
        wr_data_en = 1'b0;
        chk("f_data1", 64'(wr_data), 64'd102);
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        chk("f_bvalid", 64'(axi.bvalid), 64'd1);
        chk("f_bresp",  64'(axi.bresp),  64'd0);
        axi.bready = 1'b1;
        tick();
        axi.bready = 1'b0;
        chk("f_bdone", 64'(axi.bvalid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
